dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single data read port of the memory controller between the load path (high priority) and the stream prefetcher (low priority). It keeps exactly one request in flight, matches the controller's broadcast response to that request by address, and routes the data back to the owner. A load that hits the address of an in-flight prefetch is merged onto it instead of being issued twice. A starvation counter guarantees the prefetcher forward progress.

## Interface
- STARVE_LIMIT, 4: consecutive load grants allowed while a prefetch waits; legal 1..15.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ld_req  in  1  load request; held with ld_addr until ld_ack seen.
- ld_addr  in  16  load word address.
- ld_ack  out  1  one-cycle pulse: load accepted (issued or merged).
- ld_valid  out  1  one-cycle pulse: ld_data valid.
- ld_data  out  16  load response data.
- pf_req  in  1  prefetch request; same hold rule as ld_req.
- pf_addr  in  16  prefetch word address.
- pf_ack  out  1  one-cycle pulse: prefetch accepted.
- pf_valid  out  1  one-cycle pulse: pf_data valid.
- pf_data  out  16  prefetch response data.
- mem_re  out  1  read enable to the controller data port; one-cycle pulse.
- mem_raddr  out  16  read address to the controller; valid while mem_re=1.
- mem_ready  in  1  controller data-response broadcast strobe.
- mem_raddr_in  in  16  address of the broadcast response.
- mem_rdata  in  16  data of the broadcast response.
- busy  out  1  high while a request is in flight (state WAIT).

## Operation
- States: IDLE, WAIT. Registers: cur_addr[15:0], owner (LD/PF), merged, starve_cnt[3:0]. All outputs registered.
- Reset (async, rst_n=0): state=IDLE, all pulses/valids=0, mem_re=0, mem_raddr=0, ld_data=pf_data=0, cur_addr=0, merged=0, starve_cnt=0, busy=0.
- IDLE grant selection, evaluated each edge:
  - pf_req && starve_cnt==STARVE_LIMIT: grant PF.
  - else ld_req: grant LD.
  - else pf_req: grant PF.
  - On grant: mem_re<=1, mem_raddr<=cur_addr<=granted addr, owner<=granted, matching ack<=1, merged<=0, state<=WAIT.
- starve_cnt: +1 on each LD grant while pf_req=1 (saturates at 15); cleared on PF grant or any edge with pf_req=0.
- WAIT:
  - mem_re and acks return to 0 after one cycle.
  - Merge: if owner=PF, merged=0, ld_req=1, ld_addr==cur_addr: ld_ack<=1, merged<=1. A load at a different address waits. A PF request during WAIT always waits.
  - Completion: mem_ready=1 && mem_raddr_in==cur_addr. Owner's valid<=1 and data<=mem_rdata; if merged, also ld_valid<=1 and ld_data<=mem_rdata. state<=IDLE.
  - mem_ready with a mismatched address (another controller's traffic) is ignored.
- Valids are one-cycle pulses; data registers hold their last value until the next response.

## Timing
- Grant at edge E (request sampled in IDLE). mem_re, mem_raddr and the ack are high during cycle E+1 only.
- Requesters drop req, or present a new address, in the cycle after ack. The arbiter is in WAIT at edge E+1, so a held req is never double-granted.
- Response: matching mem_ready sampled at edge R gives valid and data during cycle R+1, and state is IDLE from R+1.
- Earliest next grant is edge R+1, so the minimum issue spacing is memory latency + 2 cycles.
- Simultaneous ld_req and pf_req in IDLE: LD wins unless the starvation limit is reached.
- Merge and completion at the same edge: the merge applies, and both ld_valid and pf_valid pulse.
- rst_n asserted mid-WAIT: the arbiter returns to IDLE immediately. A late controller response then arrives in IDLE and is ignored, so no valid is pulsed.

## Test plan
- Single load 0x0040, memory returns 0xBEEF after 1 cycle -> ld_ack and mem_re pulse at cycle E+1 with mem_raddr=0x0040; ld_valid pulses with ld_data=0xBEEF; pf_valid stays 0.
- ld_req and pf_req asserted together at 0x0010 and 0x0020 -> load issued first; prefetch issued on the first IDLE edge after the load completes.
- pf_req held continuously and ld_req re-asserted back-to-back, STARVE_LIMIT=4 -> four load grants, then one PF grant, then starve_cnt=0.
- Prefetch 0x0100 in flight, then ld_req to 0x0100 -> ld_ack with no second mem_re; on the response 0x1234, ld_valid and pf_valid pulse in the same cycle, both carrying 0x1234.
- In WAIT for 0x0200, mem_ready with mem_raddr_in=0x0300 -> ignored and state stays WAIT; later mem_ready with 0x0200 completes the request.
- rst_n pulsed low while in WAIT, then the response arrives -> all outputs 0 and no valid pulse; a new load issues normally afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the memory controller read port between the load path and the stream
// prefetcher: one request in flight, address-matched response, load-onto-prefetch merging.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic [15:0] ld_addr,
  output logic        ld_ack,
  output logic        ld_valid,
  output logic [15:0] ld_data,
  input  logic        pf_req,
  input  logic [15:0] pf_addr,
  output logic        pf_ack,
  output logic        pf_valid,
  output logic [15:0] pf_data,
  output logic        mem_re,
  output logic [15:0] mem_raddr,
  input  logic        mem_ready,
  input  logic [15:0] mem_raddr_in,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_LD, OWN_PF} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  owner_t      owner;
  logic [15:0] cur_addr;
  logic        merged;
  logic [3:0]  starve_cnt;
  logic        merge_hit;
  logic        resp_hit;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // A load may ride on an in-flight prefetch only once, and only at the same word.
  assign merge_hit = (owner == OWN_PF) && !merged && ld_req && (ld_addr == cur_addr);
  assign resp_hit  = mem_ready && (mem_raddr_in == cur_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_LD;
      cur_addr   <= '0;
      merged     <= 1'b0;
      starve_cnt <= '0;
      ld_ack     <= 1'b0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
      pf_ack     <= 1'b0;
      pf_valid   <= 1'b0;
      pf_data    <= '0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_re   <= 1'b0;
      ld_ack   <= 1'b0;
      pf_ack   <= 1'b0;
      ld_valid <= 1'b0;
      pf_valid <= 1'b0;
      if (!pf_req) starve_cnt <= '0;

      case (state)
        IDLE: begin
          if (pf_req && (starve_cnt == LIMIT)) begin
            mem_re     <= 1'b1;
            mem_raddr  <= pf_addr;
            cur_addr   <= pf_addr;
            owner      <= OWN_PF;
            pf_ack     <= 1'b1;
            merged     <= 1'b0;
            starve_cnt <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end else if (ld_req) begin
            mem_re    <= 1'b1;
            mem_raddr <= ld_addr;
            cur_addr  <= ld_addr;
            owner     <= OWN_LD;
            ld_ack    <= 1'b1;
            merged    <= 1'b0;
            if (pf_req) starve_cnt <= sat_inc(starve_cnt);
            busy      <= 1'b1;
            state     <= WAIT;
          end else if (pf_req) begin
            mem_re     <= 1'b1;
            mem_raddr  <= pf_addr;
            cur_addr   <= pf_addr;
            owner      <= OWN_PF;
            pf_ack     <= 1'b1;
            merged     <= 1'b0;
            starve_cnt <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (merge_hit) begin
            ld_ack <= 1'b1;
            merged <= 1'b1;
          end
          // Responses for other addresses belong to other controller clients.
          if (resp_hit) begin
            if (owner == OWN_PF) begin
              pf_valid <= 1'b1;
              pf_data  <= mem_rdata;
            end
            if ((owner == OWN_LD) || merged || merge_hit) begin
              ld_valid <= 1'b1;
              ld_data  <= mem_rdata;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expectations are queued by the stimulus and
// consumed by a monitor whenever the arbiter issues, acks a merge, or returns data.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [15:0] ld_addr = '0;
  logic        ld_ack, ld_valid;
  logic [15:0] ld_data;
  logic        pf_req = 1'b0;
  logic [15:0] pf_addr = '0;
  logic        pf_ack, pf_valid;
  logic [15:0] pf_data;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_ready;
  logic [15:0] mem_raddr_in, mem_rdata;
  logic        busy;

  logic        auto_en = 1'b0, auto_ready = 1'b0, man_ready = 1'b0;
  logic [15:0] auto_addr = '0, auto_data = '0, man_addr = '0, man_data = '0;

  assign mem_ready    = auto_ready | man_ready;
  assign mem_raddr_in = auto_ready ? auto_addr : man_addr;
  assign mem_rdata    = auto_ready ? auto_data : man_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_valid(ld_valid), .ld_data(ld_data),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack), .pf_valid(pf_valid), .pf_data(pf_data),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready),
    .mem_raddr_in(mem_raddr_in), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [16:0] exp_issue[$];  // {is_pf, addr}
  logic [15:0] exp_merge[$];
  logic [15:0] exp_ld[$];
  logic [15:0] exp_pf[$];
  logic [16:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re) begin
        chk("issue_expected", 32'(exp_issue.size() != 0), 32'd1);
        if (exp_issue.size() != 0) begin
          mon_e = exp_issue.pop_front();
          chk("issue_addr", 32'(mem_raddr), 32'(mon_e[15:0]));
          chk("issue_pf_ack", 32'(pf_ack), 32'(mon_e[16]));
          chk("issue_ld_ack", 32'(ld_ack), 32'(!mon_e[16]));
        end
      end else begin
        if (ld_ack) begin
          chk("merge_expected", 32'(exp_merge.size() != 0), 32'd1);
          if (exp_merge.size() != 0) chk("merge_addr", 32'(ld_addr), 32'(exp_merge.pop_front()));
        end
        chk("pf_ack_without_issue", 32'(pf_ack), 32'd0);
      end
      if (ld_valid) begin
        chk("ld_valid_expected", 32'(exp_ld.size() != 0), 32'd1);
        if (exp_ld.size() != 0) chk("ld_data", 32'(ld_data), 32'(exp_ld.pop_front()));
      end
      if (pf_valid) begin
        chk("pf_valid_expected", 32'(exp_pf.size() != 0), 32'd1);
        if (exp_pf.size() != 0) chk("pf_data", 32'(pf_data), 32'(exp_pf.pop_front()));
      end
    end
  end

  // Auto memory: answers one cycle after the read pulse with data = ~addr.
  always begin
    @(negedge clk);
    if (auto_en && rst_n && mem_re) begin
      auto_addr = mem_raddr;
      @(posedge clk); #1;
      auto_ready = 1'b1;
      auto_data  = ~auto_addr;
      @(posedge clk); #1;
      auto_ready = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 100) begin tick(); c++; end
    chk(name, 32'(busy), 32'd0);
    tick(); tick();
  endtask

  task automatic issue_ld(input logic [15:0] a, input string name);
    int c = 0;
    ld_req = 1'b1; ld_addr = a;
    do begin tick(); c++; end while (!ld_ack && c < 100);
    chk(name, 32'(ld_ack), 32'd1);
    ld_req = 1'b0;
  endtask

  task automatic issue_pf(input logic [15:0] a, input string name);
    int c = 0;
    pf_req = 1'b1; pf_addr = a;
    do begin tick(); c++; end while (!pf_ack && c < 100);
    chk(name, 32'(pf_ack), 32'd1);
    pf_req = 1'b0;
  endtask

  task automatic issue_both(input logic [15:0] la, input logic [15:0] pa, input string name);
    int c = 0;
    ld_req = 1'b1; ld_addr = la; pf_req = 1'b1; pf_addr = pa;
    while ((ld_req || pf_req) && c < 200) begin
      tick(); c++;
      if (ld_ack) ld_req = 1'b0;
      if (pf_ack) pf_req = 1'b0;
    end
    chk(name, 32'(ld_req | pf_req), 32'd0);
    ld_req = 1'b0; pf_req = 1'b0;
  endtask

  initial begin
    int lds;
    int c;
    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_acks", 32'({ld_ack, pf_ack}), 32'd0);
    chk("rst_valids", 32'({ld_valid, pf_valid}), 32'd0);
    chk("rst_ld_data", 32'(ld_data), 32'd0);
    chk("rst_pf_data", 32'(pf_data), 32'd0);
    tick(); rst_n = 1'b1; tick();

    // Single load, one-cycle memory latency
    exp_issue.push_back({1'b0, 16'h0040});
    exp_ld.push_back(16'hBEEF);
    issue_ld(16'h0040, "t1_ld_ack");
    chk("t1_mem_re", 32'(mem_re), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    man_ready = 1'b1; man_addr = 16'h0040; man_data = 16'hBEEF;
    tick();
    man_ready = 1'b0;
    chk("t1_ld_valid", 32'(ld_valid), 32'd1);
    chk("t1_ld_data", 32'(ld_data), 32'hBEEF);
    chk("t1_pf_valid", 32'(pf_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    wait_idle("t1_done");

    // Simultaneous requests: load first, then prefetch
    auto_en = 1'b1;
    exp_issue.push_back({1'b0, 16'h0010});
    exp_issue.push_back({1'b1, 16'h0020});
    exp_ld.push_back(16'hFFEF);
    exp_pf.push_back(16'hFFDF);
    issue_both(16'h0010, 16'h0020, "t2_both_acked");
    wait_idle("t2_done");

    // Starvation: four loads then one prefetch while both are held
    for (int i = 0; i < 4; i++) begin
      exp_issue.push_back({1'b0, 16'h0050});
      exp_ld.push_back(16'hFFAF);
    end
    exp_issue.push_back({1'b1, 16'h0060});
    exp_pf.push_back(16'hFF9F);
    ld_req = 1'b1; ld_addr = 16'h0050; pf_req = 1'b1; pf_addr = 16'h0060;
    lds = 0; c = 0;
    while (pf_req && c < 400) begin
      tick(); c++;
      if (ld_ack) lds++;
      if (pf_ack) begin pf_req = 1'b0; ld_req = 1'b0; end
    end
    chk("t3_pf_granted", 32'(pf_req), 32'd0);
    chk("t3_load_grants", 32'(lds), 32'd4);
    ld_req = 1'b0; pf_req = 1'b0;
    wait_idle("t3_done");
    // Counter cleared by the prefetch grant: load wins again
    exp_issue.push_back({1'b0, 16'h0070});
    exp_issue.push_back({1'b1, 16'h0080});
    exp_ld.push_back(16'hFF8F);
    exp_pf.push_back(16'hFF7F);
    issue_both(16'h0070, 16'h0080, "t3_after_clear");
    wait_idle("t3_clear_done");

    // Load merged onto in-flight prefetch
    auto_en = 1'b0;
    exp_issue.push_back({1'b1, 16'h0100});
    exp_merge.push_back(16'h0100);
    exp_ld.push_back(16'h1234);
    exp_pf.push_back(16'h1234);
    issue_pf(16'h0100, "t4_pf_ack");
    issue_ld(16'h0100, "t4_merge_ack");
    chk("t4_no_reissue", 32'(mem_re), 32'd0);
    man_ready = 1'b1; man_addr = 16'h0100; man_data = 16'h1234;
    tick();
    man_ready = 1'b0;
    chk("t4_both_valid", 32'({ld_valid, pf_valid}), 32'd3);
    chk("t4_ld_data", 32'(ld_data), 32'h1234);
    chk("t4_pf_data", 32'(pf_data), 32'h1234);
    wait_idle("t4_done");

    // Foreign response ignored
    exp_issue.push_back({1'b0, 16'h0200});
    exp_ld.push_back(16'h7777);
    issue_ld(16'h0200, "t5_ld_ack");
    man_ready = 1'b1; man_addr = 16'h0300; man_data = 16'hDEAD;
    tick();
    man_ready = 1'b0;
    chk("t5_still_busy", 32'(busy), 32'd1);
    chk("t5_no_valid", 32'(ld_valid), 32'd0);
    tick();
    man_ready = 1'b1; man_addr = 16'h0200; man_data = 16'h7777;
    tick();
    man_ready = 1'b0;
    chk("t5_ld_valid", 32'(ld_valid), 32'd1);
    chk("t5_ld_data", 32'(ld_data), 32'h7777);
    wait_idle("t5_done");

    // Reset while waiting; late response must be dropped
    exp_issue.push_back({1'b0, 16'h0400});
    issue_ld(16'h0400, "t6_ld_ack");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mem", 32'({mem_re, mem_raddr}), 32'd0);
    chk("t6_rst_ld_data", 32'(ld_data), 32'd0);
    chk("t6_rst_pf_data", 32'(pf_data), 32'd0);
    tick();
    rst_n = 1'b1;
    man_ready = 1'b1; man_addr = 16'h0400; man_data = 16'h9999;
    tick();
    man_ready = 1'b0;
    chk("t6_late_no_valid", 32'({ld_valid, pf_valid}), 32'd0);
    chk("t6_late_idle", 32'(busy), 32'd0);
    tick();
    auto_en = 1'b1;
    exp_issue.push_back({1'b0, 16'h0500});
    exp_ld.push_back(16'hFAFF);
    issue_ld(16'h0500, "t6_new_ack");
    wait_idle("t6_done");

    chk("left_issue", 32'(exp_issue.size()), 32'd0);
    chk("left_merge", 32'(exp_merge.size()), 32'd0);
    chk("left_ld", 32'(exp_ld.size()), 32'd0);
    chk("left_pf", 32'(exp_pf.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
